// File: rtl/tick_arbiter.sv
// Two-stage tick divider that issues one round-robin slot grant among four
// requesters on every slot tick. All outputs come straight from flops.
module tick_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       pi_en,
  input  logic [7:0] pi_div,
  input  logic [3:0] pi_mul,
  input  logic [3:0] pi_req,
  output logic       po_tick1,
  output logic       po_tick,
  output logic [3:0] po_gnt,
  output logic [1:0] po_gnt_id,
  output logic       po_miss
);

  logic [7:0] div_s;
  logic [3:0] mul_s;
  logic [7:0] cnt1;
  logic [3:0] cnt2;
  logic [1:0] ptr;
  logic       pick_found;
  logic [1:0] pick_idx;

  // Walk from the farthest candidate back to ptr so the nearest requester wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] result;
    logic [1:0] idx;
    result = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) begin
        result = {1'b1, idx};
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Round-robin selection for the current request vector and pointer.
  always_comb begin
    {pick_found, pick_idx} = rr_pick(pi_req, ptr);
  end

  // Counters, configuration shadows, pointer and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_s     <= pi_div;
      mul_s     <= pi_mul;
      cnt1      <= 8'd0;
      cnt2      <= 4'd0;
      ptr       <= 2'd0;
      po_tick1  <= 1'b0;
      po_tick   <= 1'b0;
      po_gnt    <= 4'b0000;
      po_gnt_id <= 2'd0;
      po_miss   <= 1'b0;
    end else if (!pi_en) begin
      po_tick1 <= 1'b0;
      po_tick  <= 1'b0;
      po_gnt   <= 4'b0000;
      po_miss  <= 1'b0;
    end else if (cnt1 == div_s) begin
      // New configuration only takes effect at a wrap, keeping counters in range.
      cnt1     <= 8'd0;
      div_s    <= pi_div;
      mul_s    <= pi_mul;
      po_tick1 <= 1'b1;
      if (cnt2 == mul_s) begin
        cnt2    <= 4'd0;
        po_tick <= 1'b1;
        if (pick_found) begin
          po_gnt    <= onehot4(pick_idx);
          po_gnt_id <= pick_idx;
          ptr       <= pick_idx + 2'd1;
          po_miss   <= 1'b0;
        end else begin
          po_gnt  <= 4'b0000;
          po_miss <= 1'b1;
        end
      end else begin
        cnt2    <= cnt2 + 4'd1;
        po_tick <= 1'b0;
        po_gnt  <= 4'b0000;
        po_miss <= 1'b0;
      end
    end else begin
      cnt1     <= cnt1 + 8'd1;
      po_tick1 <= 1'b0;
      po_tick  <= 1'b0;
      po_gnt   <= 4'b0000;
      po_miss  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_arbiter.sv
// Scoreboard bench for tick_arbiter: stimulus queues expected tick events with
// their edge numbers, a negedge monitor pops and compares them.
module tb_tick_arbiter;

  logic       clk;
  logic       rst;
  logic       pi_en;
  logic [7:0] pi_div;
  logic [3:0] pi_mul;
  logic [3:0] pi_req;
  logic       po_tick1;
  logic       po_tick;
  logic [3:0] po_gnt;
  logic [1:0] po_gnt_id;
  logic       po_miss;

  tick_arbiter dut (
    .clk(clk), .rst(rst), .pi_en(pi_en), .pi_div(pi_div), .pi_mul(pi_mul),
    .pi_req(pi_req), .po_tick1(po_tick1), .po_tick(po_tick), .po_gnt(po_gnt),
    .po_gnt_id(po_gnt_id), .po_miss(po_miss)
  );

  typedef struct {
    int         cyc;
    logic       tick;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       miss;
  } ev_t;

  ev_t  exp_q[$];
  int   cyc = 0;
  logic rst_d = 1'b0;
  logic done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  task automatic tick_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic t, input logic [3:0] g, input logic [1:0] id, input logic m);
    ev_t e;
    e.cyc = c; e.tick = t; e.gnt = g; e.id = id; e.miss = m;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(output int e0);
    rst = 1'b1;
    tick_wait(1);
    e0  = cyc;
    rst = 1'b0;
  endtask

  // Monitor: reset-state check after every reset edge, event compare otherwise.
  always @(negedge clk) begin
    ev_t e;
    if (rst_d) begin
      checks++;
      if (po_tick1 !== 1'b0 || po_tick !== 1'b0 || po_gnt !== 4'b0000 || po_gnt_id !== 2'd0 || po_miss !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got tick1=%b tick=%b gnt=%b id=%0d miss=%b required all zero",
                 cyc, po_tick1, po_tick, po_gnt, po_gnt_id, po_miss);
      end
    end else if (po_tick1 === 1'b1 || po_tick === 1'b1 || po_miss === 1'b1 || (|po_gnt) === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got tick1=%b tick=%b gnt=%b miss=%b required no event",
                 cyc, po_tick1, po_tick, po_gnt, po_miss);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || po_tick1 !== 1'b1 || po_tick !== e.tick || po_gnt !== e.gnt ||
            po_gnt_id !== e.id || po_miss !== e.miss) begin
          errors++;
          $display("FAIL event got cyc=%0d tick1=%b tick=%b gnt=%b id=%0d miss=%b required cyc=%0d tick1=1 tick=%b gnt=%b id=%0d miss=%b",
                   cyc, po_tick1, po_tick, po_gnt, po_gnt_id, po_miss, e.cyc, e.tick, e.gnt, e.id, e.miss);
        end
      end
    end
    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pending_events got %0d left required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    logic [3:0] slot_gnt [10];
    logic [1:0] slot_id  [10];
    logic [1:0] cur_id;
    int         e0;
    int         j;

    slot_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0000, 4'b0100};
    slot_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2};
    rst = 1'b1; pi_en = 1'b1; pi_div = 8'd3; pi_mul = 4'd15; pi_req = 4'b0000;

    // V1: period 4, slot every 64 cycles, every slot a miss
    do_reset(e0);
    for (int k = 1; k <= 32; k++) begin
      push(e0 + 4 * k, (k % 16) == 0, 4'b0000, 2'd0, (k % 16) == 0);
    end
    tick_wait(128);

    // V4: minimum period, grants rotate every cycle; reset then aborts a due tick
    pi_div = 8'd0; pi_mul = 4'd0; pi_req = 4'b1111;
    do_reset(e0);
    for (int k = 1; k <= 8; k++) begin
      push(e0 + k, 1'b1, 4'b0001 << ((k - 1) % 4), 2'((k - 1) % 4), 1'b0);
    end
    tick_wait(8);

    // V2/V3: slot every 4 cycles; rotation, pointer skip, miss, forgotten requests
    pi_div = 8'd1; pi_mul = 4'd1; pi_req = 4'b1111;
    do_reset(e0);
    cur_id = 2'd0;
    for (int k = 1; k <= 20; k++) begin
      if (k % 2 == 0) begin
        j = k / 2;
        cur_id = slot_id[j - 1];
        push(e0 + 2 * k, 1'b1, slot_gnt[j - 1], cur_id, j == 9);
      end else begin
        push(e0 + 2 * k, 1'b0, 4'b0000, cur_id, 1'b0);
      end
    end
    tick_wait(24);
    pi_req = 4'b0011;
    tick_wait(8);
    pi_req = 4'b1000;
    tick_wait(3);
    pi_req = 4'b0000;
    tick_wait(1);
    pi_req = 4'b1000;
    tick_wait(3);
    pi_req = 4'b0100;
    tick_wait(1);

    // V5: divider change mid-period, then a 5-cycle enable gap
    pi_div = 8'd9; pi_mul = 4'd15; pi_req = 4'b0000;
    do_reset(e0);
    push(e0 + 10, 1'b0, 4'b0000, 2'd0, 1'b0);
    push(e0 + 12, 1'b0, 4'b0000, 2'd0, 1'b0);
    push(e0 + 14, 1'b0, 4'b0000, 2'd0, 1'b0);
    push(e0 + 16, 1'b0, 4'b0000, 2'd0, 1'b0);
    push(e0 + 23, 1'b0, 4'b0000, 2'd0, 1'b0);
    push(e0 + 25, 1'b0, 4'b0000, 2'd0, 1'b0);
    push(e0 + 27, 1'b0, 4'b0000, 2'd0, 1'b0);
    tick_wait(4);
    pi_div = 8'd1;
    tick_wait(12);
    pi_en = 1'b0;
    tick_wait(5);
    pi_en = 1'b1;
    tick_wait(6);

    // V6: reset at cnt2=7 with last grant id 3, then rotation restarts at 0
    pi_div = 8'd0; pi_mul = 4'd15; pi_req = 4'b1111;
    do_reset(e0);
    cur_id = 2'd0;
    for (int k = 1; k <= 71; k++) begin
      if (k % 16 == 0) begin
        cur_id = 2'(k / 16 - 1);
        push(e0 + k, 1'b1, 4'b0001 << cur_id, cur_id, 1'b0);
      end else begin
        push(e0 + k, 1'b0, 4'b0000, cur_id, 1'b0);
      end
    end
    tick_wait(71);
    do_reset(e0);
    for (int k = 1; k <= 16; k++) begin
      push(e0 + k, k == 16, (k == 16) ? 4'b0001 : 4'b0000, 2'd0, 1'b0);
    end
    tick_wait(16);
    done = 1'b1;
  end

endmodule

// File: doc/tick_arbiter.md
TICK_ARBITER -- requirements
Module: tick_arbiter

Interface
REQ-001 The block SHALL expose the ports below, in this order:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- pi_en  input  1  run enable; low freezes counters and suppresses ticks and grants
- pi_div  input  8  stage-1 period minus 1
- pi_mul  input  4  stage-2 count minus 1, in stage-1 ticks
- pi_req  input  4  per-requester slot request, level-sensitive
- po_tick1  output  1  stage-1 tick, 1-cycle pulse
- po_tick  output  1  slot tick, 1-cycle pulse
- po_gnt  output  4  one-hot slot grant, 1-cycle pulse
- po_gnt_id  output  2  index of the last granted requester
- po_miss  output  1  slot tick occurred with no request

REQ-002 Clock and reset: one clock, clk; reset is synchronous and active-high, rst.

REQ-003 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Function
REQ-004 Shadow registers div_s (8b) and mul_s (4b) SHALL load pi_div and pi_mul on every rst cycle and on every stage-1 wrap; otherwise they hold.
REQ-005 Stage-1 counter cnt1 (8b) SHALL increment by 1 each cycle with pi_en=1; when cnt1==div_s it SHALL wrap to 0 and register po_tick1=1 for exactly that next cycle.
REQ-006 The stage-1 period SHALL be div_s+1 cycles; div_s=0 SHALL produce po_tick1 high on every enabled cycle.
REQ-007 Stage-2 counter cnt2 (4b) SHALL advance only on stage-1 wraps; at a wrap with cnt2==mul_s it SHALL clear to 0 and register po_tick=1 coincident with po_tick1.
REQ-008 The slot period SHALL be (div_s+1)*(mul_s+1) cycles; the maximum is 256*16=4096.
REQ-009 Grant: on the edge that registers po_tick=1, the block SHALL sample pi_req and register po_gnt. The registered grant SHALL be one-hot for the first requester at or after pointer ptr (2b), searching upward mod 4.
REQ-010 After a grant to index i, ptr SHALL become (i+1) mod 4, and po_gnt_id SHALL become i and hold until the next grant.
REQ-011 If pi_req==0 at a slot tick: po_gnt=0, po_miss=1 for that cycle, and ptr and po_gnt_id unchanged.
REQ-012 po_gnt SHALL be 0 on every cycle where po_tick=0; requests between slot ticks SHALL NOT be remembered.
REQ-013 With pi_en=0: cnt1, cnt2, ptr and the shadows SHALL hold, and po_tick1, po_tick, po_gnt and po_miss SHALL be 0. Counting SHALL resume from the held values when pi_en returns to 1.
REQ-014 A change of pi_div or pi_mul mid-period SHALL NOT affect the current stage-1 period; it takes effect from the next wrap, so no out-of-range counter value can occur.
REQ-015 rst SHALL take priority over pi_en and over all tick and grant events in the same cycle.

Reset
REQ-016 On any cycle with rst=1, the block SHALL set:
- cnt1=0, cnt2=0, ptr=0
- po_tick1=0, po_tick=0, po_gnt=0, po_gnt_id=0, po_miss=0
- shadows loaded per REQ-004
REQ-017 A reset asserted mid-period SHALL abort the period. The first po_tick1 after rst deasserts, with pi_en=1, SHALL follow the rst-low edge by div_s+1 cycles.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- V1 Period check. pi_div=3, pi_mul=15, pi_en=1, no requests, rst released at edge E0. Required: po_tick1 at E4, E8, ...; po_tick at E64, E128, ...; po_miss=1 with each po_tick.
- V2 Round-robin under full load. pi_req=4'b1111. Required: successive slots grant 0001, 0010, 0100, 1000, 0001; po_gnt_id=0,1,2,3,0.
- V3 Pointer skip. ptr=2, pi_req=4'b0011 at a slot. Required: grant 0001, ptr becomes 1; the next slot with 4'b0011 grants 0010.
- V4 Minimum period. pi_div=0, pi_mul=0. Required: po_tick1=po_tick=1 every cycle, and grants rotate every cycle with pi_req=4'b1111.
- V5 Mid-period config change and enable gap. With pi_div=9, set pi_div=1 at cnt1=4. Required: the current period stays 10 and subsequent periods are 2. Drop pi_en for 5 cycles. Required: no ticks, and the tick is delayed by exactly 5 cycles.
- V6 Reset mid-operation. Assert rst for 1 cycle at cnt2=7 while po_gnt_id=3. Required: all outputs 0 the next cycle, ptr=0, and the next slot with 4'b1111 grants 0001.
